ana_pad_mux_ctrl: RTL



---
 rtl/ana_pad_pkg.sv | 25 ++
 rtl/ana_pad_dly_cnt.sv | 30 +++
 rtl/ana_pad_mux_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ana_pad_pkg.sv
// Shared types and helpers for the analog pad switch-bank controller.
package ana_pad_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int MAX_NCH   = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        SETTLE    = 2'd2,
        CONNECTED = 2'd3
    } state_e;

    // One-hot switch pattern for channel idx; all-zero when idx is outside the bank.
    function automatic logic [MAX_NCH-1:0] onehot(input logic [31:0] idx, input int n);
        logic [MAX_NCH-1:0] res;
        if (idx < 32'(n)) begin
            res = 32'd1 << idx;
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ana_pad_dly_cnt.sv
// Loadable down-counter used for both the break-before-make dead time and the settle interval.
module ana_pad_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);
    logic [CNT_W-1:0] cnt_r;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value = cnt_r;
    assign done  = (cnt_r == '0);

endmodule

// File: rtl/ana_pad_mux_ctrl.sv
// Analog pad switch-bank controller: connects at most one pad channel to the shared
// analog node, with break-before-make dead time and a settle interval before settled.
module ana_pad_mux_ctrl
    import ana_pad_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int SEL_W      = $clog2(NCH),
    parameter int BBM_CYC    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_ch,
    input  logic             req_en,
    output logic [NCH-1:0]   sw_en,
    output logic [SEL_W-1:0] active_ch,
    output logic             busy,
    output logic             settled,
    output logic             err_range
);
    localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_e           state_r, state_s;
    logic             conn_r, conn_s;
    logic [SEL_W-1:0] active_ch_r, ch_s;
    logic [NCH-1:0]   sw_en_r, sw_en_s;
    logic             busy_r, busy_s;
    logic             settled_r, settled_s;
    logic             err_range_r, err_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_done_s;
    logic [CNT_W-1:0] cnt_val_unused_s;
    logic             accept_s;
    logic             in_range_s;

    assign req_ready  = ((state_r == IDLE) || (state_r == CONNECTED)) && !rst;
    assign accept_s   = req_valid && req_ready;
    assign in_range_s = (32'(req_ch) < 32'(NCH));

    ana_pad_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .value    (cnt_val_unused_s),
        .done     (cnt_done_s)
    );

    // State register: sequencing state, connect/disconnect path and target channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            conn_r      <= 1'b0;
            active_ch_r <= '0;
        end else begin
            state_r     <= state_s;
            conn_r      <= conn_s;
            active_ch_r <= ch_s;
        end
    end

    // Next-state logic; a disconnect runs the full dead time even from IDLE.
    always_comb begin
        state_s        = state_r;
        conn_s         = conn_r;
        ch_s           = active_ch_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = BBM_LOAD;
        err_s          = 1'b0;
        case (state_r)
            IDLE, CONNECTED: begin
                if (!accept_s) begin
                    state_s = state_r;
                end else if (!req_en) begin
                    state_s    = BREAK;
                    conn_s     = 1'b0;
                    cnt_load_s = 1'b1;
                end else if (!in_range_s) begin
                    err_s = 1'b1;
                end else if ((state_r == CONNECTED) && (req_ch == active_ch_r)) begin
                    state_s = state_r;
                end else begin
                    state_s    = BREAK;
                    conn_s     = 1'b1;
                    ch_s       = req_ch;
                    cnt_load_s = 1'b1;
                end
            end
            BREAK: begin
                if (!cnt_done_s) begin
                    state_s = BREAK;
                end else if (!conn_r) begin
                    state_s = IDLE;
                end else if (SETTLE_CYC > 0) begin
                    state_s        = SETTLE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = SETTLE_LOAD;
                end else begin
                    state_s = CONNECTED;
                end
            end
            SETTLE: begin
                if (cnt_done_s) begin
                    state_s = CONNECTED;
                end else begin
                    state_s = SETTLE;
                end
            end
            default: begin
                state_s = IDLE;
                conn_s  = 1'b0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        sw_en_s   = '0;
        busy_s    = 1'b0;
        settled_s = 1'b0;
        case (state_s)
            IDLE: begin
                sw_en_s = '0;
            end
            BREAK: begin
                busy_s = 1'b1;
            end
            SETTLE: begin
                sw_en_s = NCH'(onehot(32'(ch_s), NCH));
                busy_s  = 1'b1;
            end
            CONNECTED: begin
                sw_en_s   = NCH'(onehot(32'(ch_s), NCH));
                settled_s = 1'b1;
            end
            default: begin
                sw_en_s = '0;
            end
        endcase
    end

    // Output registers; reset opens every switch immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_en_r     <= '0;
            busy_r      <= 1'b0;
            settled_r   <= 1'b0;
            err_range_r <= 1'b0;
        end else begin
            sw_en_r     <= sw_en_s;
            busy_r      <= busy_s;
            settled_r   <= settled_s;
            err_range_r <= err_s;
        end
    end

    assign sw_en     = sw_en_r;
    assign active_ch = active_ch_r;
    assign busy      = busy_r;
    assign settled   = settled_r;
    assign err_range = err_range_r;

endmodule
